pwm_capture8: RTL and testbench
===============================

Name: pwm_capture8

Overview:
- Eight-channel PWM decoder; the measuring counterpart of the 8-output PWM generator.
- Samples eight external PWM inputs and measures high time and period of each, in clk cycles.
- Exposes results on the same 8-bit addr / rd / wr / 32-bit data register bus the generator's register block uses, so a bus master can read back servo/motor drive waveforms for closed-loop checks.

Parameters:
- CNT_W, 32, width of the high-time and period counters (≤32; zero-extended onto the data bus).
- TIMEOUT, 2000000, cycles without a rising edge before a channel is declared stale (20 ms at 100 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pwm_in  input  8  raw PWM inputs, asynchronous to clk; bit i = channel i.
- addr  input  8  register address.
- rd  input  1  read strobe, one cycle per access.
- wr  input  1  write strobe, one cycle per access.
- d_in  input  32  write data.
- d_out  output  32  read data, registered.
- valid  output  8  per-channel measurement-valid flags (mirror of STATUS[7:0]).

Behaviour:
- Reset: asserting rst_n low asynchronously clears every register:
  - d_out = 0, valid = 0, all HIGH/PERIOD registers = 0, all counters = 0, synchronizers = 0, timeout counters = 0.
  - Reset mid-pulse discards the partial measurement. The first rising edge after reset only starts counting and does not latch.
- Input path: each pwm_in[i] passes a 2-FF synchronizer plus a third register for edge detect. Edges are therefore seen 3 cycles after the pin changes. Rising/falling edge detect is one-cycle pulses.
- Per-channel measurement, 2-state FSM, ARMED → RUN:
  - ARMED (after reset or timeout): counters held at 0; a rising edge → RUN, hi_cnt = 1, per_cnt = 1.
  - RUN, every cycle: per_cnt += 1; hi_cnt += 1 while synchronized level is 1. Both counters saturate at 2^CNT_W−1 and never wrap.
  - RUN, rising edge: HIGH[i] ← hi_cnt, PERIOD[i] ← per_cnt, valid[i] ← 1, then hi_cnt = 1, per_cnt = 1, all in the same cycle.
  - Falling edge: no latch; it only stops hi_cnt.
  - Timeout: per-channel counter reset on every rising edge. On reaching TIMEOUT → valid[i] ← 0, HIGH[i] ← 0 if level is 0 else PERIOD-less full-on, encoded HIGH[i] ← 2^CNT_W−1 and PERIOD[i] ← 0; FSM → ARMED. A constant-level input is thus reported as 0% or 100% and is never valid.
- Register map (read):
  - 0x00–0x07: HIGH[0..7].
  - 0x08–0x0F: PERIOD[0..7].
  - 0x10: STATUS = {16'b0, level[7:0], valid[7:0]}.
  - 0x11: CTRL = {31'b0, freeze}.
  - Any other address reads 0.
- Read timing:
  - d_out is updated on the clock edge where rd=1, so data is valid the cycle after rd. It holds until the next rd.
  - Without rd, d_out holds its value.
  - A read of HIGH/PERIOD in the same cycle as a latch returns the old value.
- Coherence: while freeze=1, HIGH/PERIOD/valid are not updated (counters keep running). The master sets freeze, reads one channel pair, then clears freeze.
- Write:
  - Addr 0x10: valid[i] ← 0 for every d_in[i]=1 (write-1-to-clear); HIGH/PERIOD untouched.
  - Addr 0x11: freeze ← d_in[0].
  - Writes to any other address are ignored.
  - If a clear-write coincides with a latch on the same channel, the latch wins and valid stays 1.
  - rd and wr in the same cycle: both are performed. Read data is the pre-write value.

Test Plan:
- Reset: drive rst_n=0 mid-run with pwm_in toggling → d_out=0, valid=0 immediately (asynchronous); after release, read 0x00 → 0.
- Steady PWM on ch3, high 150 cycles / period 1000:
  - After the second rising edge, read 0x03 → 150, read 0x0B → 1000, valid=8'h08.
  - rd asserted at cycle t → data on d_out at t+1.
- Timeout (TIMEOUT=5000 for sim): ch0 held high for >5000 cycles:
  - valid[0]=0, HIGH[0]=FFFFFFFF, PERIOD[0]=0.
  - Ch1 held low → HIGH[1]=0.
- Freeze: write 0x11←1, change ch5 to 300/2000 for 3 periods, read 0x05 → old value; write 0x11←0 → next period reads 300.
- W1C race: write 0x10←8'hFF in the exact cycle ch2 latches → STATUS reads valid[2]=1, others 0.
- Unmapped/saturation: read 0x20 → 0. With CNT_W=8 and period 400, PERIOD reads 255 and HIGH saturates at 255.

Source files
------------

// File: rtl/pwm_capture8_if.sv
// Register bus shared with the PWM generator: 8-bit address, one-cycle rd/wr strobes, 32-bit data.
// Read data is registered in the slave and appears the cycle after rd.
// No backpressure: every strobe is accepted in the cycle it is presented.
interface pwm_capture8_if;
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_in;
    logic [31:0] d_out;

    modport master (output addr, rd, wr, d_in, input d_out);
    modport slave  (input addr, rd, wr, d_in, output d_out);
endinterface

// File: rtl/pwm_capture8.sv
// Eight-channel PWM decoder: measures high time and period of async inputs, reports them on a register bus.
// Edges act 3 cycles after the pin changes; read data appears the cycle after rd.
// No backpressure: reads and writes complete in one cycle, measurement never stalls.
module pwm_capture8 #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    pwm_in,
    pwm_capture8_if.slave bus,
    output logic [7:0]    valid
);
    localparam int               TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {ARMED = 1'b0, RUN = 1'b1} state_e;

    logic [7:0]       sync1_q, sync2_q, sync3_q;
    logic [7:0]       level, rise;
    state_e           state_q   [8];
    state_e           state_d   [8];
    logic [CNT_W-1:0] hi_cnt_q  [8];
    logic [CNT_W-1:0] hi_cnt_d  [8];
    logic [CNT_W-1:0] per_cnt_q [8];
    logic [CNT_W-1:0] per_cnt_d [8];
    logic [CNT_W-1:0] high_q    [8];
    logic [CNT_W-1:0] high_d    [8];
    logic [CNT_W-1:0] period_q  [8];
    logic [CNT_W-1:0] period_d  [8];
    logic [TO_W-1:0]  to_q      [8];
    logic [TO_W-1:0]  to_d      [8];
    logic [7:0]       valid_q, valid_d;
    logic             freeze_q, freeze_d;
    logic [31:0]      d_out_q, d_out_d;
    logic [31:0]      rdata;
    logic             wr_status, wr_ctrl;
    logic             unused_d_in;

    // Only the low byte of write data carries meaning (W1C mask / freeze bit).
    assign unused_d_in = ^bus.d_in[31:8];

    assign level     = sync2_q;
    assign rise      = sync2_q & ~sync3_q;
    assign wr_status = bus.wr && (bus.addr == 8'h10);
    assign wr_ctrl   = bus.wr && (bus.addr == 8'h11);
    assign valid     = valid_q;
    assign bus.d_out = d_out_q;

    // Two-flop synchronizer plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Read mux over the current (pre-update) register contents; counters are zero-extended.
    always_comb begin
        rdata = '0;
        if (bus.addr[7:3] == 5'd0) begin
            rdata[CNT_W-1:0] = high_q[bus.addr[2:0]];
        end else if (bus.addr[7:3] == 5'd1) begin
            rdata[CNT_W-1:0] = period_q[bus.addr[2:0]];
        end else if (bus.addr == 8'h10) begin
            rdata = {16'b0, level, valid_q};
        end else if (bus.addr == 8'h11) begin
            rdata = {31'b0, freeze_q};
        end
    end

    // Per-channel ARMED/RUN next state, counters, latching, timeout and bus writes.
    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        high_d    = high_q;
        period_d  = period_q;
        to_d      = to_q;
        valid_d   = valid_q;
        freeze_d  = freeze_q;
        d_out_d   = bus.rd ? rdata : d_out_q;

        // W1C is applied first so a coincident latch below wins.
        if (wr_status) begin
            valid_d = valid_q & ~bus.d_in[7:0];
        end
        if (wr_ctrl) begin
            freeze_d = bus.d_in[0];
        end

        for (int i = 0; i < 8; i++) begin
            if (rise[i] || (to_q[i] == TO_LAST)) begin
                to_d[i] = '0;
            end else begin
                to_d[i] = to_q[i] + TO_W'(1);
            end

            if (rise[i]) begin
                // First edge after ARMED only starts the measurement.
                if ((state_q[i] == RUN) && !freeze_q) begin
                    high_d[i]   = hi_cnt_q[i];
                    period_d[i] = per_cnt_q[i];
                    valid_d[i]  = 1'b1;
                end
                state_d[i]   = RUN;
                hi_cnt_d[i]  = CNT_ONE;
                per_cnt_d[i] = CNT_ONE;
            end else if (to_q[i] == TO_LAST) begin
                // Stale input: report constant level as 0% or full-on, never valid.
                if (!freeze_q) begin
                    valid_d[i]  = 1'b0;
                    high_d[i]   = level[i] ? CNT_MAX : '0;
                    period_d[i] = '0;
                end
                state_d[i]   = ARMED;
                hi_cnt_d[i]  = '0;
                per_cnt_d[i] = '0;
            end else if (state_q[i] == RUN) begin
                if (per_cnt_q[i] != CNT_MAX) begin
                    per_cnt_d[i] = per_cnt_q[i] + CNT_ONE;
                end
                if (level[i] && (hi_cnt_q[i] != CNT_MAX)) begin
                    hi_cnt_d[i] = hi_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // State and register update; reset discards any partial measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                state_q[i]   <= ARMED;
                hi_cnt_q[i]  <= '0;
                per_cnt_q[i] <= '0;
                high_q[i]    <= '0;
                period_q[i]  <= '0;
                to_q[i]      <= '0;
            end
            valid_q  <= '0;
            freeze_q <= 1'b0;
            d_out_q  <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                state_q[i]   <= state_d[i];
                hi_cnt_q[i]  <= hi_cnt_d[i];
                per_cnt_q[i] <= per_cnt_d[i];
                high_q[i]    <= high_d[i];
                period_q[i]  <= period_d[i];
                to_q[i]      <= to_d[i];
            end
            valid_q  <= valid_d;
            freeze_q <= freeze_d;
            d_out_q  <= d_out_d;
        end
    end
endmodule

// File: tb/tb_pwm_capture8.sv
// Bench for pwm_capture8: a 32-bit and an 8-bit counter instance share stimulus and are
// compared every cycle against an edge-timestamp model, plus literal anchor checks.
// Stimulus: per-channel PWM generators, directed phases, then randomized traffic.
module tb_pwm_capture8;
    localparam int     TO      = 5000;
    localparam longint FULL_ON = 64'h1_0000_0000;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [7:0]  pwm_in = '0;
    logic [7:0]  addr   = '0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [31:0] din    = '0;
    logic [7:0]  valid32, valid8;

    pwm_capture8_if bus32 ();
    pwm_capture8_if bus8 ();

    assign bus32.addr = addr;
    assign bus32.rd   = rd;
    assign bus32.wr   = wr;
    assign bus32.d_in = din;
    assign bus8.addr  = addr;
    assign bus8.rd    = rd;
    assign bus8.wr    = wr;
    assign bus8.d_in  = din;

    pwm_capture8 #(.CNT_W(32), .TIMEOUT(TO)) dut32 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .bus(bus32), .valid(valid32));
    pwm_capture8 #(.CNT_W(8), .TIMEOUT(TO)) dut8 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .bus(bus8), .valid(valid8));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: timestamps of synchronized edges ----------------
    longint      m_high [8];
    longint      m_per [8];
    longint      m_rise_t [8];
    longint      m_fall_t [8];
    longint      m_anchor [8];
    bit          m_run [8];
    bit          m_fall_seen [8];
    logic [7:0]  m_valid;
    logic        m_freeze, m_nf;
    logic [7:0]  h1, h2, h3, m_rise, m_fall;
    longint      n;
    logic [31:0] exp32, exp8;

    function automatic logic [31:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (v > mx) return mx[31:0];
        return v[31:0];
    endfunction

    function automatic logic [31:0] rdval(input logic [7:0] a, input int w);
        if (a < 8'h08) return sat(m_high[a[2:0]], w);
        if (a < 8'h10) return sat(m_per[a[2:0]], w);
        if (a == 8'h10) return {16'b0, h2, m_valid};
        if (a == 8'h11) return {31'b0, m_freeze};
        return 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 8; c++) begin
                m_high[c] = 0; m_per[c] = 0; m_rise_t[c] = 0; m_fall_t[c] = 0;
                m_anchor[c] = 0; m_run[c] = 1'b0; m_fall_seen[c] = 1'b0;
            end
            m_valid = '0; m_freeze = 1'b0; h1 = '0; h2 = '0; h3 = '0;
            n = 0; exp32 = '0; exp8 = '0;
        end else begin
            n++;
            m_rise = h2 & ~h3;
            m_fall = ~h2 & h3;
            if (rd) begin
                exp32 = rdval(addr, 32);
                exp8  = rdval(addr, 8);
            end
            if (wr && addr == 8'h10) m_valid = m_valid & ~din[7:0];
            m_nf = m_freeze;
            if (wr && addr == 8'h11) m_nf = din[0];
            for (int c = 0; c < 8; c++) begin
                if (m_rise[c]) begin
                    if (m_run[c] && !m_freeze) begin
                        m_high[c]  = (m_fall_seen[c] ? m_fall_t[c] : n) - m_rise_t[c];
                        m_per[c]   = n - m_rise_t[c];
                        m_valid[c] = 1'b1;
                    end
                    m_run[c] = 1'b1; m_rise_t[c] = n; m_fall_seen[c] = 1'b0; m_anchor[c] = n;
                end else if (n - m_anchor[c] == TO) begin
                    if (!m_freeze) begin
                        m_valid[c] = 1'b0;
                        m_high[c]  = h2[c] ? FULL_ON : 0;
                        m_per[c]   = 0;
                    end
                    m_run[c] = 1'b0; m_anchor[c] = n;
                end
                if (m_fall[c] && m_run[c]) begin
                    m_fall_seen[c] = 1'b1; m_fall_t[c] = n;
                end
            end
            m_freeze = m_nf;
            h3 = h2; h2 = h1; h1 = pwm_in;
        end
    end

    // Every cycle: both instances' outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_dout32", bus32.d_out, exp32);
            chk("cyc_dout8", bus8.d_out, exp8);
            chk("cyc_valid32", {24'b0, valid32}, {24'b0, m_valid});
            chk("cyc_valid8", {24'b0, valid8}, {24'b0, m_valid});
        end
    end

    // ---------------- stimulus ----------------
    int g_hi [8];
    int g_per [8];
    int g_ph [8];

    task automatic set_ch(input int c, input int hi, input int per);
        g_hi[c] = hi; g_per[c] = per; g_ph[c] = 0;
    endtask

    task automatic drive_pins();
        for (int c = 0; c < 8; c++) begin
            if (g_per[c] == 0) begin
                pwm_in[c] = (g_hi[c] != 0);
            end else begin
                pwm_in[c] = (g_ph[c] < g_hi[c]);
                g_ph[c]   = (g_ph[c] + 1) % g_per[c];
            end
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_pins();
        rd = r; wr = w; addr = a; din = d;
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return 8'($urandom_range(8'h12, 8'hFF));
        return 8'($urandom_range(0, 8'h11));
    endfunction

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if ($urandom_range(0, 7) == 0) cyc(1'b1, 1'b0, rand_addr(), 32'd0);
            else                           cyc(1'b0, 1'b0, 8'd0, 32'd0);
        end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d);
        cyc(1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    // rd presented for one edge; data must be on d_out one cycle later.
    task automatic rd_chk(input logic [7:0] a, input logic [31:0] e32, input logic [31:0] e8,
                          input string nm);
        cyc(1'b1, 1'b0, a, 32'd0);
        cyc(1'b0, 1'b0, 8'd0, 32'd0);
        chk({nm, "_32"}, bus32.d_out, e32);
        chk({nm, "_8"}, bus8.d_out, e8);
        chk({nm, "_model"}, exp32, e32);
    endtask

    initial begin
        bit   found;
        logic p;
        for (int c = 0; c < 8; c++) set_ch(c, 0, 0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("rst_dout32", bus32.d_out, 32'd0);
        chk("rst_valid32", {24'b0, valid32}, 32'd0);
        rd_chk(8'h00, 32'd0, 32'd0, "rst_high0");

        // Steady ch3 150/1000, ch0 stuck high, ch1 stuck low.
        set_ch(3, 150, 1000);
        set_ch(0, 1, 0);
        idle(2500);
        rd_chk(8'h03, 32'd150, 32'd150, "ch3_high");
        rd_chk(8'h0B, 32'd1000, 32'd255, "ch3_period");
        chk("ch3_valid", {24'b0, valid32}, 32'h08);
        chk("ch3_valid_model", {24'b0, m_valid}, 32'h08);

        // Timeouts.
        idle(3000);
        rd_chk(8'h00, 32'hFFFF_FFFF, 32'h0000_00FF, "to_high0");
        rd_chk(8'h08, 32'd0, 32'd0, "to_period0");
        rd_chk(8'h01, 32'd0, 32'd0, "to_high1");
        chk("to_valid0", {31'b0, valid32[0]}, 32'd0);

        // Freeze keeps the old ch5 result until released.
        set_ch(5, 100, 2000);
        idle(4500);
        wr_reg(8'h11, 32'd1);
        set_ch(5, 300, 2000);
        idle(6500);
        rd_chk(8'h05, 32'd100, 32'd100, "frz_hold");
        wr_reg(8'h11, 32'd0);
        idle(4500);
        rd_chk(8'h05, 32'd300, 32'd255, "frz_release");

        // W1C coinciding with a ch2 latch.
        set_ch(3, 0, 0);
        set_ch(5, 0, 0);
        set_ch(2, 200, 800);
        idle(2000);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            p = pwm_in[2];
            cyc(1'b0, 1'b0, 8'd0, 32'd0);
            if (pwm_in[2] && !p) found = 1'b1;
        end
        chk("w1c_edge_found", {31'b0, found}, 32'd1);
        cyc(1'b0, 1'b0, 8'd0, 32'd0);
        cyc(1'b0, 1'b1, 8'h10, 32'h0000_00FF);
        cyc(1'b1, 1'b0, 8'h10, 32'd0);
        chk("w1c_valid", {24'b0, valid32}, 32'h04);
        cyc(1'b0, 1'b0, 8'd0, 32'd0);
        chk("w1c_status", {24'b0, bus32.d_out[7:0]}, 32'h04);

        // Saturation on the 8-bit instance, unmapped read.
        set_ch(4, 300, 400);
        idle(1500);
        rd_chk(8'h04, 32'd300, 32'd255, "sat_high4");
        rd_chk(8'h0C, 32'd400, 32'd255, "sat_period4");
        rd_chk(8'h20, 32'd0, 32'd0, "unmapped");

        // Randomized traffic.
        for (int c = 0; c < 8; c++) begin
            int per;
            per = $urandom_range(20, 600);
            if ($urandom_range(0, 7) == 0) set_ch(c, $urandom_range(0, 1), 0);
            else                           set_ch(c, $urandom_range(0, per), per);
        end
        for (int k = 0; k < 8000; k++) begin
            int sel;
            sel = $urandom_range(0, 39);
            if (sel < 6)       cyc(1'b1, 1'b0, rand_addr(), 32'd0);
            else if (sel == 6) cyc(1'b0, 1'b1, 8'h10, $urandom);
            else if (sel == 7) cyc(1'b0, 1'b1, 8'h11, {31'b0, ($urandom_range(0, 3) == 0)});
            else if (sel == 8) cyc(1'b1, 1'b1, 8'h10, $urandom);
            else if (sel == 9) cyc(1'b1, 1'b1, 8'h11, 32'd0);
            else               cyc(1'b0, 1'b0, 8'd0, 32'd0);
        end
        wr_reg(8'h11, 32'd0);
        idle(1000);

        // Asynchronous reset mid-run with inputs toggling.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout32", bus32.d_out, 32'd0);
        chk("arst_dout8", bus8.d_out, 32'd0);
        chk("arst_valid32", {24'b0, valid32}, 32'd0);
        repeat (3) cyc(1'b0, 1'b0, 8'd0, 32'd0);
        rst_n = 1'b1;
        rd_chk(8'h00, 32'd0, 32'd0, "arst_high0");
        idle(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
